bw_mult_arbiter: RTL and testbench
==================================

// Module: bw_mult_arbiter
// PURPOSE
//   Shares one combinational 4x4 signed BaughWooley multiplier (A, B -> prod) between two requesters.
//   Round-robin arbiter plus FSM: registers the winner's operands, waits MUL_LAT settle cycles,
//   captures prod, then holds the result on a valid/ready output tagged with the requester id.
//   Sits between operand producers and the shared multiplier instance, which is instantiated inside.
// PARAMETERS
//   MUL_LAT  1  settle cycles between operand register load and prod capture; legal range 1..15
// PORTS
//   clk         in   1  single clock, all state updates on rising edge
//   rst         in   1  synchronous, active-high reset
//   req0_valid  in   1  requester 0 holds operands valid
//   req0_ready  out  1  requester 0 operands accepted this cycle
//   req0_a      in   4  requester 0 multiplicand, two's complement
//   req0_b      in   4  requester 0 multiplier, two's complement
//   req1_valid  in   1  as req0_valid, requester 1
//   req1_ready  out  1  as req0_ready, requester 1
//   req1_a      in   4  as req0_a, requester 1
//   req1_b      in   4  as req0_b, requester 1
//   res_valid   out  1  result valid
//   res_ready   in   1  consumer accepts result
//   res_prod    out  8  signed product A*B, two's complement
//   res_id      out  1  requester that owns res_prod
//   busy        out  1  high in MUL or DONE
// BEHAVIOUR
//   Reset: state=IDLE; last=1 so req0 wins the first tie. Outputs: res_valid=0, res_prod=0, res_id=0,
//     busy=0, req*_ready=0. Operand regs and counter are cleared.
//   FSM states: IDLE -> MUL -> DONE -> IDLE.
//   IDLE:
//     - reqN_ready is combinational: (state==IDLE) & grantN & !rst.
//     - Grant with one valid goes to that requester.
//     - Grant with both valid goes to the requester != last.
//     - On handshake (valid & ready): op_a/op_b <= reqN_a/b, id <= N, last <= N,
//       cnt <= MUL_LAT-1, state <= MUL.
//     - Nothing valid: stay in IDLE.
//   MUL:
//     - op_a/op_b drive BaughWooley.A/.B; no ready is asserted.
//     - cnt==0: res_prod <= prod, res_id <= id, res_valid <= 1, state <= DONE.
//     - Otherwise cnt <= cnt-1.
//   DONE:
//     - res_valid, res_prod and res_id are held stable until res_ready.
//     - On res_valid & res_ready: res_valid <= 0, state <= IDLE.
//     - res_prod and res_id keep their last value.
//   Latency: handshake in cycle T gives res_valid high from cycle T+MUL_LAT+1.
//     Minimum issue interval is MUL_LAT+2 cycles. No new accept in the same cycle as a result drain.
//   Requester rules:
//     - A requester holds valid and operands until ready.
//     - Operands are sampled only in the handshake cycle; later changes do not affect the result.
//     - A non-granted requester waits with no state change.
//     - Fairness: a requester that is continuously valid is served within 2 grants.
//   Arithmetic: res_prod = sext8(A)*sext8(B) truncated to 8 bits; the full range is exact
//     (-8*-8 = +64 = 8'h40).
//   rst asserted in MUL or DONE aborts immediately; any in-flight result is dropped.
//   res_ready held high while res_valid=0 is ignored.
// TESTING
//   1. Reset, then req0 alone with a=3, b=5 -> req0_ready=1 for one cycle; res_valid at T+2
//      (MUL_LAT=1) with res_prod=8'h0F, res_id=0.
//   2. req0 and req1 both valid, continuously (a=-8,b=-8 / a=7,b=-8) -> grants alternate 0,1,0,1;
//      products 8'h40 and 8'hC8 with matching res_id.
//   3. Backpressure: res_ready=0 for 5 cycles -> res_valid stays high, res_prod stable,
//      req*_ready stay 0; then res_ready=1 -> drain, IDLE next cycle.
//   4. Exhaustive sweep of all 256 (a,b) pairs on req1 -> every res_prod equals the signed
//      reference product; also run with MUL_LAT=3, where latency = 4 cycles.
//   5. Assert rst during MUL and again during DONE -> next cycle res_valid=0, busy=0, state IDLE;
//      with both valid afterwards, req0 is granted first.
//   6. Change req0_a/b after the handshake (a=-1,b=1 captured, then a=7) -> res_prod=8'hFF.

Source files
------------

// File: rtl/bw_mult_arbiter.sv
// bw_mult_arbiter
//   Two-requester round-robin front end for one shared 4x4 signed Baugh-Wooley multiplier.
//   A granted requester's operands are registered. After MUL_LAT settle cycles the product is
//   captured and held on a valid/ready result port, tagged with the owning requester id.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req{0,1}_valid/_ready        operand handshake per requester
//   req{0,1}_a, req{0,1}_b       4-bit two's complement operands
//   res_valid/res_ready          result handshake
//   res_prod                     8-bit signed product
//   res_id                       requester that owns res_prod
//   busy                         high while a multiply is in flight or a result is pending
module bw_mult_arbiter #(
   parameter int unsigned MUL_LAT = 1  // legal range 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_prod,
   output logic       res_id,
   output logic       busy
);

   localparam logic [3:0] CntLoad = 4'(MUL_LAT - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e     state_q, state_d;
   logic       last_q, last_d;
   logic [3:0] op_a_q, op_a_d;
   logic [3:0] op_b_q, op_b_d;
   logic       id_q, id_d;
   logic [3:0] cnt_q, cnt_d;
   logic       res_valid_q, res_valid_d;
   logic [7:0] res_prod_q, res_prod_d;
   logic       res_id_q, res_id_d;

   logic       grant0, grant1;
   logic [7:0] prod;
   logic       pp;

   // Baugh-Wooley: partial products that pair exactly one sign bit with a magnitude bit are
   // inverted, and the correction constant 2^4 + 2^7 restores the signed result mod 2^8.
   always_comb begin
      prod = 8'd0;
      pp   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pp = op_a_q[i] & op_b_q[j];
            if ((i == 3) != (j == 3)) pp = ~pp;
            prod = prod + (8'(pp) << (i + j));
         end
      end
      prod = prod + 8'h90;
   end

   // On a tie the requester that did not win last time gets the grant.
   assign grant0 = req0_valid & (~req1_valid | last_q);
   assign grant1 = req1_valid & (~req0_valid | ~last_q);

   assign req0_ready = (state_q == StIdle) & grant0 & ~rst;
   assign req1_ready = (state_q == StIdle) & grant1 & ~rst;

   assign res_valid = res_valid_q;
   assign res_prod  = res_prod_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q == StMul) | (state_q == StDone);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      res_prod_d  = res_prod_q;
      res_id_d    = res_id_q;
      unique case (state_q)
         StIdle: begin
            if (req0_ready) begin
               op_a_d  = req0_a;
               op_b_d  = req0_b;
               id_d    = 1'b0;
               last_d  = 1'b0;
               cnt_d   = CntLoad;
               state_d = StMul;
            end else if (req1_ready) begin
               op_a_d  = req1_a;
               op_b_d  = req1_b;
               id_d    = 1'b1;
               last_d  = 1'b1;
               cnt_d   = CntLoad;
               state_d = StMul;
            end
         end
         StMul: begin
            if (cnt_q == 4'd0) begin
               res_prod_d  = prod;
               res_id_d    = id_q;
               res_valid_d = 1'b1;
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            // Result is held until consumed; no new accept in the drain cycle.
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         op_a_q      <= 4'd0;
         op_b_q      <= 4'd0;
         id_q        <= 1'b0;
         cnt_q       <= 4'd0;
         res_valid_q <= 1'b0;
         res_prod_q  <= 8'd0;
         res_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_prod_q  <= res_prod_d;
         res_id_q    <= res_id_d;
      end
   end

endmodule

// File: tb/tb_bw_mult_arbiter.sv
module tb_bw_mult_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid, res_ready;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_ready, req1_ready, res_valid, res_id, busy;
   logic [7:0] res_prod;
   logic       r3_req0_ready, r3_req1_ready, r3_res_valid, r3_res_id, r3_busy;
   logic [7:0] r3_res_prod;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bw_mult_arbiter #(.MUL_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod), .res_id(res_id),
      .busy(busy)
   );

   bw_mult_arbiter #(.MUL_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r3_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(r3_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res_valid(r3_res_valid), .res_ready(res_ready), .res_prod(r3_res_prod),
      .res_id(r3_res_id), .busy(r3_busy)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Waits for a grant, checks which requester won, then checks latency, product and id.
   task automatic run_txn(input string tag, input logic [1:0] exp_grant, input logic exp_id,
                          input logic [7:0] exp_prod);
      int n;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_grant"}, {14'd0, req1_ready, req0_ready}, {14'd0, exp_grant});
      tick();
      n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 16'(n), 16'd1);
      check({tag, "_res"}, {7'd0, res_id, res_prod}, {7'd0, exp_id, exp_prod});
      res_ready = 1'b1;
      tick();
   endtask

   logic [3:0]        a4, b4;
   logic signed [7:0] exp_p;
   logic [8:0]        p1, p3;
   int                lat1, lat3;

   initial begin
      req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
      res_ready = 1'b0;
      req1_valid = 1'b0;

      // 1: reset state, ready gated by rst, single request 3*5
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
      tick();
      tick();
      check("rst_out", {5'd0, res_valid, res_id, busy, res_prod}, 16'h0000);
      check("rst_rdy", {14'd0, req1_ready, req0_ready}, 16'h0000);
      rst = 1'b0;
      #1;
      check("t1_rdy", {14'd0, req1_ready, req0_ready}, 16'h0001);
      tick();
      req0_valid = 1'b0;
      check("t1_mul", {14'd0, busy, res_valid}, 16'h0002);
      tick();
      check("t1_res", {6'd0, res_valid, res_id, res_prod}, {6'd0, 1'b1, 1'b0, 8'h0F});
      res_ready = 1'b1;
      tick();
      check("t1_drain", {14'd0, busy, res_valid}, 16'h0000);

      // 2: both continuously valid -> alternating grants starting with req0
      do_reset();
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 4'h8; req0_b = 4'h8;
      req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h8;
      #1;
      run_txn("rr0", 2'b01, 1'b0, 8'h40);
      run_txn("rr1", 2'b10, 1'b1, 8'hC8);
      run_txn("rr2", 2'b01, 1'b0, 8'h40);
      run_txn("rr3", 2'b10, 1'b1, 8'hC8);

      // 3: backpressure holds the result; the other requester wins after the drain
      do_reset();
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
      #1;
      check("bp_rdy", {14'd0, req1_ready, req0_ready}, 16'h0001);
      tick();
      req0_a = 4'hF; req0_b = 4'hF;
      req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_hold", {5'd0, res_valid, req1_ready, req0_ready, res_prod},
               {5'd0, 1'b1, 1'b0, 1'b0, 8'h06});
         tick();
      end
      res_ready = 1'b1;
      tick();
      check("bp_drain", {14'd0, busy, res_valid}, 16'h0000);
      check("bp_fair", {14'd0, req1_ready, req0_ready}, 16'h0002);

      // 4: exhaustive sweep on req1, both latency variants in lockstep
      do_reset();
      res_ready = 1'b1;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            a4 = 4'(ai);
            b4 = 4'(bi);
            exp_p = $signed({{4{a4[3]}}, a4}) * $signed({{4{b4[3]}}, b4});
            req1_a = a4; req1_b = b4; req1_valid = 1'b1;
            #1;
            check("sw_rdy", {12'd0, r3_req0_ready, r3_req1_ready, req0_ready, req1_ready},
                  16'h0005);
            tick();
            req1_valid = 1'b0;
            lat1 = 0; lat3 = 0; p1 = 9'd0; p3 = 9'd0;
            for (int k = 1; k <= 8; k++) begin
               if (res_valid && lat1 == 0) begin
                  lat1 = k;
                  p1 = {res_id, res_prod};
               end
               if (r3_res_valid && lat3 == 0) begin
                  lat3 = k;
                  p3 = {r3_res_id, r3_res_prod};
               end
               tick();
            end
            check("sw_p1", 16'(p1), {7'd0, 1'b1, exp_p});
            check("sw_p3", 16'(p3), {7'd0, 1'b1, exp_p});
            check("sw_lat", {lat1[7:0], lat3[7:0]}, 16'h0204);
         end
      end
      check("sw_idle", {14'd0, r3_busy, busy}, 16'h0000);

      // 5: reset aborts in MUL and in DONE, and restores req0 tie priority
      do_reset();
      req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
      #1;
      tick();
      req0_valid = 1'b0;
      check("ab_mul", {14'd0, busy, res_valid}, 16'h0002);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ab_mul_rst", {5'd0, busy, res_valid, res_id, res_prod}, 16'h0000);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("ab_mul_pri", {14'd0, req1_ready, req0_ready}, 16'h0001);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      check("ab_done", {14'd0, busy, res_valid}, 16'h0003);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ab_done_rst", {5'd0, busy, res_valid, res_id, res_prod}, 16'h0000);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("ab_done_pri", {14'd0, req1_ready, req0_ready}, 16'h0001);
      req0_valid = 1'b0; req1_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      check("ab_idle_rdy", {14'd0, busy, res_valid}, 16'h0000);

      // 6: operand changes after the handshake do not affect the result
      do_reset();
      req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'h1;
      #1;
      check("late_rdy", {14'd0, req1_ready, req0_ready}, 16'h0001);
      tick();
      req0_valid = 1'b0; req0_a = 4'h7;
      tick();
      check("late_res", {6'd0, res_valid, res_id, res_prod}, {6'd0, 1'b1, 1'b0, 8'hFF});
      res_ready = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
